// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg -- shared types and helpers for the seven-segment scan controller.
//   scan_state_t : conversion FSM states (IDLE, CONVERT, COMMIT)
//   SEG_BLANK    : all segments dark (active low)
//   AN_OFF       : all digit enables off (active low)
//   BCD_W        : width of the double-dabble BCD register (5 digits covers 65535)
//   bcd_add3     : double-dabble correction applied to one BCD digit before a shift
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam int         BCD_W     = 20;

    function automatic logic [3:0] bcd_add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder -- combinational hex digit to seven-segment lookup.
//   digit : 4-bit value 0..F
//   seg   : segment pattern, active low, bit order {g,f,e,d,c,b,a}
module seg_hex_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl -- drives a 4-digit common-anode seven-segment display.
// A 16-bit operand is shown as hex nibbles or as decimal (sequential double-dabble).
// New digits are committed atomically, so the scanner never shows a partial value.
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   value    : operand to display
//   mode     : 0 = decimal, 1 = hexadecimal
//   seg      : segments, active low {g,f,e,d,c,b,a}
//   an       : digit enables, active low, an[0] = least significant digit
//   busy     : decimal conversion in progress
//   overflow : decimal operand exceeds 9999 (display blanked)
// Build option: define SEEN_SEG... see below.
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN : blank leading zero digits (digit 0 always shown).
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CONV_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CONV_BITS-1:0] value,
    input  logic                 mode,
    output logic [6:0]           seg,
    output logic [3:0]           an,
    output logic                 busy,
    output logic                 overflow
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(CONV_BITS);

    scan_state_t          state, state_nxt;
    logic [CONV_BITS-1:0] cap_value;
    logic                 cap_mode;
    logic [CONV_BITS-1:0] bin_sr;
    logic [BCD_W-1:0]     bcd_sr, bcd_adj;
    logic [IW-1:0]        iter;
    logic [3:0][3:0]      digits, commit_digits;
    logic [3:0]           blank, commit_blank;
    logic                 commit_ovf;
    logic                 changed;
    logic [PW-1:0]        presc;
    logic [1:0]           idx;
    logic [6:0]           dec_seg;

    assign changed = {value, mode} != {cap_value, cap_mode};
    assign busy    = (state == CONVERT);

    // FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (changed) state_nxt = mode ? COMMIT : CONVERT;
            CONVERT: if (iter == IW'(CONV_BITS - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every BCD digit ahead of the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BCD_W / 4; i++)
            bcd_adj[4*i +: 4] = bcd_add3(bcd_sr[4*i +: 4]);
    end

    // Digits/blank/overflow to load at COMMIT.
    always_comb begin
        commit_digits = cap_mode ? cap_value[15:0] : bcd_sr[15:0];
        commit_ovf    = !cap_mode && (bcd_sr[19:16] != 4'd0);
        commit_blank  = 4'b0000;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        // A digit is blank only if it and every digit above it are zero.
        commit_blank[3] = (commit_digits[3] == 4'd0);
        commit_blank[2] = commit_blank[3] && (commit_digits[2] == 4'd0);
        commit_blank[1] = commit_blank[2] && (commit_digits[1] == 4'd0);
`endif
        if (commit_ovf) commit_blank = 4'b1111;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_value <= '0;
            cap_mode  <= 1'b0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            iter      <= '0;
            digits    <= '0;
            blank     <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (changed) begin
                    cap_value <= value;
                    cap_mode  <= mode;
                    bin_sr    <= value;
                    bcd_sr    <= '0;
                    iter      <= '0;
                end
                CONVERT: begin
                    bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[CONV_BITS-1]};
                    bin_sr <= bin_sr << 1;
                    iter   <= iter + 1'b1;
                end
                COMMIT: begin
                    digits   <= commit_digits;
                    blank    <= commit_blank;
                    overflow <= commit_ovf;
                end
                default: ;
            endcase
        end
    end

    // Scanner: free-running, reads only committed digits.
    seg_hex_decoder u_dec (
        .digit (digits[idx]),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= 2'd0;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
        end else begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= blank[idx] ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb_seven_segment_scan_ctrl -- self-checking bench for seven_segment_scan_ctrl.
// Expected display is computed arithmetically from the operand (division / shifts),
// then compared against whichever digit the scanner is enabling each cycle.
module tb_seven_segment_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        mode;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] cur_v;
    logic        cur_m;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seven_segment_scan_ctrl #(.REFRESH_DIV(DIV), .CONV_BITS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .mode     (mode),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pow10(input int p);
        int r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    // Reference: what digit position p should show for operand v in mode m.
    function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic m, input int p);
        int q;
        int d;
        if (!m && v > 16'd9999) return 7'b1111111;
        q = m ? (int'(v) >> (4 * p)) : (int'(v) / pow10(p));
        d = m ? (q % 16) : (q % 10);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (p > 0 && q == 0) return 7'b1111111;
`endif
        return seg_tab[d];
    endfunction

    task automatic chk_disp(input string tag, input logic [15:0] v, input logic m);
        int p;
        case (an)
            4'b1110: p = 0;
            4'b1101: p = 1;
            4'b1011: p = 2;
            4'b0111: p = 3;
            default: p = -1;
        endcase
        if (p < 0) chk({tag, "_an"}, an, 4'b1110);
        else       chk(tag, seg, exp_seg(v, m, p));
    endtask

    // Present a new operand and check busy timing, overflow and the scanned display.
    task automatic apply_run(input logic [15:0] v, input logic m);
        value = v;
        mode  = m;
        cur_v = v;
        cur_m = m;
        if (m) begin
            for (int k = 1; k <= 2; k++) begin
                step();
                chk("busy_hex", busy, 0);
            end
            chk("ovf_hex", overflow, 0);
            for (int k = 3; k <= 18; k++) begin
                step();
                chk_disp("disp_hex", v, m);
            end
        end else begin
            for (int k = 1; k <= 18; k++) begin
                step();
                chk("busy_dec", busy, (k <= 16));
            end
            chk("ovf_dec", overflow, (v > 16'd9999));
            for (int k = 19; k <= 34; k++) begin
                step();
                chk_disp("disp_dec", v, m);
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        logic        m;
        logic [3:0]  ea;

        reset = 1'b1;
        value = 16'd0;
        mode  = 1'b0;
        step();
        step();
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_an", an, 4'b1111);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);

        // Scan order after reset release, display of the reset digits.
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            ea = ~(4'b0001 << (((n - 1) / DIV) % 4));
            chk("scan_an", an, ea);
            chk_disp("scan_seg", 16'd0, 1'b0);
            chk("scan_busy", busy, 0);
        end

        apply_run(16'hBEEF, 1'b1);
        apply_run(16'd1234, 1'b0);
        apply_run(16'd10000, 1'b0);
        apply_run(16'd9999, 1'b0);

        // Operand changes during conversion: 1234 commits, then 42 is converted.
        value = 16'd1234;
        mode  = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            step();
            chk("mid_busy", busy, ((k <= 16) || (k >= 19 && k <= 34)));
            if (k >= 19 && k <= 36) chk_disp("mid_first", 16'd1234, 1'b0);
            if (k >= 37)            chk_disp("mid_second", 16'd42, 1'b0);
            if (k == 5) value = 16'd42;
        end

        // Reset during conversion.
        value = 16'd1234;
        for (int k = 1; k <= 8; k++) step();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_an", an, 4'b1111);
        chk("arst_seg", seg, 7'b1111111);
        chk("arst_ovf", overflow, 0);
        value = 16'd0;
        step();
        chk("rst_hold_an", an, 4'b1111);
        chk("rst_hold_seg", seg, 7'b1111111);
        chk("rst_hold_busy", busy, 0);
        reset = 1'b0;
        cur_v = 16'd0;
        cur_m = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            chk("post_rst_busy", busy, 0);
            chk_disp("post_rst_disp", 16'd0, 1'b0);
        end

        // Randomized operands.
        for (int t = 0; t < 24; t++) begin
            do begin
                case ($urandom % 4)
                    0:       v = 16'($urandom_range(0, 9999));
                    1:       v = 16'($urandom);
                    2:       v = 16'($urandom_range(0, 99));
                    default: v = 16'($urandom_range(9990, 10010));
                endcase
                m = 1'($urandom % 2);
            end while ({v, m} == {cur_v, cur_m});
            apply_run(v, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
